// File: rtl/dct_addr_pkg.sv
// Shared definitions for the DCT transpose-buffer address sequencer:
// scan mode encodings and the sequencer state type.
package dct_addr_pkg;

    localparam logic [1:0] MODE_LIN = 2'b00;
    localparam logic [1:0] MODE_TRN = 2'b01;
    localparam logic [1:0] MODE_DIR = 2'b10;
    localparam logic [1:0] MODE_SRP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DIRECT = 2'd2
    } seq_state_e;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder with enable; output is all-zero
// when en is low.
module onehot_dec #(
    parameter int ADDR_W = 6
) (
    input  logic                     en,
    input  logic [ADDR_W-1:0]        bin,
    output logic [(1<<ADDR_W)-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[bin] = 1'b1;
    end

endmodule

// File: rtl/onehot_addr_sequencer.sv
// Registered one-hot address sequencer for the 8x8 DCT transpose buffer:
// linear, transposed or direct access. Define ONEHOT_SEQ_SERPENTINE_EN to make mode 11 serpentine.
module onehot_addr_sequencer
    import dct_addr_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int COL_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [ADDR_W-1:0]        dir_addr,
    input  logic                     dir_valid,
    input  logic                     adv,
    output logic [(1<<ADDR_W)-1:0]   sel,
    output logic                     sel_valid,
    output logic [ADDR_W-1:0]        addr,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int                N    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    generate
        if (ADDR_W != 2 * COL_W) begin : g_bad_params
            $error("onehot_addr_sequencer: transposed scan needs ADDR_W == 2*COL_W");
        end
    endgenerate

    function automatic logic [ADDR_W-1:0] map_addr(input logic [1:0] md,
                                                   input logic [ADDR_W-1:0] c);
        logic [ADDR_W-1:0] r;
        r = c;
        case (md)
            MODE_TRN: r = {c[COL_W-1:0], c[ADDR_W-1:COL_W]};
`ifdef ONEHOT_SEQ_SERPENTINE_EN
            // odd rows run their columns backwards
            MODE_SRP: r = {c[ADDR_W-1:COL_W], c[COL_W] ? ~c[COL_W-1:0] : c[COL_W-1:0]};
`endif
            default:  r = c;
        endcase
        return r;
    endfunction

    seq_state_e              state_q, state_d;
    logic [ADDR_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [1:0]              mode_q, mode_d;
    logic [ADDR_W-1:0]       addr_p0, addr_p1;
    logic                    vld_p0, vld_p1;
    logic [N-1:0]            sel_p0, sel_p1;
    logic                    last_acc;

    assign cnt_inc = cnt_q + ADDR_W'(1);

    // p0: next strobe address/valid from the control state and handshake
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        addr_p0  = addr_p1;
        vld_p0   = vld_p1;
        last_acc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mode == MODE_DIR && dir_valid) begin
                    state_d = ST_DIRECT;
                    mode_d  = mode;
                    addr_p0 = dir_addr;
                    vld_p0  = 1'b1;
                end else if (mode != MODE_DIR && start) begin
                    state_d = ST_SCAN;
                    mode_d  = mode;
                    cnt_d   = '0;
                    addr_p0 = map_addr(mode, '0);
                    vld_p0  = 1'b1;
                end
            end
            ST_SCAN: begin
                if (adv) begin
                    if (cnt_q == LAST) begin
                        last_acc = 1'b1;
                        state_d  = ST_IDLE;
                        cnt_d    = '0;
                        addr_p0  = '0;
                        vld_p0   = 1'b0;
                    end else begin
                        cnt_d   = cnt_inc;
                        addr_p0 = map_addr(mode_q, cnt_inc);
                    end
                end
            end
            ST_DIRECT: begin
                if (adv) begin
                    state_d = ST_IDLE;
                    addr_p0 = '0;
                    vld_p0  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                addr_p0 = '0;
                vld_p0  = 1'b0;
            end
        endcase
    end

    onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
        .en     (vld_p0),
        .bin    (addr_p0),
        .onehot (sel_p0)
    );

    // p1: registered strobe presented downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_LIN;
            addr_p1 <= '0;
            vld_p1  <= 1'b0;
            sel_p1  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            addr_p1 <= addr_p0;
            vld_p1  <= vld_p0;
            sel_p1  <= sel_p0;
        end
    end

    assign sel        = sel_p1;
    assign addr       = addr_p1;
    assign sel_valid  = vld_p1;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = last_acc & ~rst;

endmodule

// File: tb/tb_onehot_addr_sequencer.sv
// Randomised self-checking bench for onehot_addr_sequencer against an
// integer-level scan model.
module tb_onehot_addr_sequencer;

    localparam int ADDR_W = 6;
    localparam int COL_W  = 3;
    localparam int N      = 1 << ADDR_W;
    localparam int COLS   = 1 << COL_W;
    localparam int ROWS   = 1 << (ADDR_W - COL_W);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [ADDR_W-1:0] dir_addr = '0;
    logic              dir_valid = 1'b0;
    logic              adv = 1'b0;
    logic [N-1:0]      sel;
    logic              sel_valid;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              frame_done;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model: 0 idle, 1 scanning, 2 direct
    int m_st = 0;
    int m_c = 0;
    int m_mode = 0;
    int m_daddr = 0;

    onehot_addr_sequencer #(.ADDR_W(ADDR_W), .COL_W(COL_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .dir_addr   (dir_addr),
        .dir_valid  (dir_valid),
        .adv        (adv),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .addr       (addr),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic int exp_map(int md, int c);
        int r;
        int col;
        r   = c / COLS;
        col = c % COLS;
        if (md == 1) return col * ROWS + r;
`ifdef ONEHOT_SEQ_SERPENTINE_EN
        if (md == 3) return (r % 2 == 1) ? r * COLS + (COLS - 1 - col) : c;
`endif
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_st <= 0;
            m_c  <= 0;
        end else begin
            case (m_st)
                0: begin
                    if (mode == 2'b10 && dir_valid) begin
                        m_st <= 2;
                        m_daddr <= int'(dir_addr);
                    end else if (mode != 2'b10 && start) begin
                        m_st <= 1;
                        m_c <= 0;
                        m_mode <= int'(mode);
                    end
                end
                1: if (adv) begin
                    if (m_c == N - 1) begin
                        m_st <= 0;
                        m_c <= 0;
                    end else begin
                        m_c <= m_c + 1;
                    end
                end
                default: if (adv) m_st <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [63:0] e_addr;
            logic [63:0] e_sel;
            logic        e_vld;
            logic        e_fd;
            e_vld  = (m_st != 0);
            e_addr = (m_st == 1) ? 64'(exp_map(m_mode, m_c)) :
                     (m_st == 2) ? 64'(m_daddr) : 64'd0;
            e_sel  = e_vld ? (64'd1 << e_addr) : 64'd0;
            e_fd   = !rst && m_st == 1 && adv && m_c == N - 1;
            chk("sel_valid", 64'(sel_valid), 64'(e_vld));
            chk("addr", 64'(addr), e_addr);
            chk("sel", 64'(sel), e_sel);
            chk("busy", 64'(busy), 64'(e_vld));
            chk("frame_done", 64'(frame_done), 64'(e_fd));
            chk("onehot_inv", 64'($countones(sel)), sel_valid ? 64'd1 : 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic run_to_idle(input string name, input int budget);
        for (int i = 0; i < budget && m_st != 0; i++) step();
        at_neg();
        chk(name, 64'(busy), 64'd0);
        step();
    endtask

    initial begin
        // reset
        step();
        chk_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        at_neg();
        chk("reset_sel", 64'(sel), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        step();

        // linear scan, adv held high
        mode = 2'b00; start = 1'b1;
        step();
        start = 1'b0; adv = 1'b1;
        at_neg();
        chk("lin_first_addr", 64'(addr), 64'd0);
        chk("lin_first_sel", 64'(sel), 64'd1);
        repeat (63) step();
        at_neg();
        chk("lin_last_addr", 64'(addr), 64'd63);
        chk("lin_last_done", 64'(frame_done), 64'd1);
        step();
        at_neg();
        chk("lin_after_idle", 64'(sel_valid), 64'd0);
        repeat (3) step();

        // transposed scan with random stalls and ignored requests
        mode = 2'b01; start = 1'b1; adv = 1'b0;
        step();
        start = 1'b0; adv = 1'b1;
        step();
        at_neg();
        chk("trn_step1_addr", 64'(addr), 64'd8);
        for (int i = 0; i < 3000 && m_st != 0; i++) begin
            adv       = ($urandom_range(0, 2) == 0);
            start     = $urandom_range(0, 1);
            dir_valid = $urandom_range(0, 1);
            mode      = 2'($urandom_range(0, 3));
            dir_addr  = ADDR_W'($urandom);
            step();
        end
        start = 1'b0; dir_valid = 1'b0; adv = 1'b0;
        at_neg();
        chk("trn_end_idle", 64'(busy), 64'd0);
        step();

        // direct access with three stalled cycles
        mode = 2'b10; dir_addr = 6'd45; dir_valid = 1'b1;
        step();
        dir_valid = 1'b0;
        at_neg();
        chk("dir_sel45", 64'(sel), 64'd1 << 45);
        chk("dir_addr", 64'(addr), 64'd45);
        repeat (3) step();
        adv = 1'b1;
        step();
        adv = 1'b0;
        at_neg();
        chk("dir_cleared", 64'(sel_valid), 64'd0);
        step();

        // dir_valid ignored in linear mode; start+dir_valid in direct mode
        mode = 2'b00; dir_valid = 1'b1;
        step();
        at_neg();
        chk("ign_dir_busy", 64'(busy), 64'd0);
        mode = 2'b10; start = 1'b1; dir_addr = 6'd7;
        step();
        start = 1'b0; dir_valid = 1'b0;
        at_neg();
        chk("both_direct_addr", 64'(addr), 64'd7);
        adv = 1'b1;
        step();
        adv = 1'b0;
        step();

        // reset in the middle of a scan
        mode = 2'b00; start = 1'b1;
        step();
        start = 1'b0; adv = 1'b1;
        for (int i = 0; i < 100 && m_c != 20; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0; adv = 1'b0;
        at_neg();
        chk("midrst_valid", 64'(sel_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        mode = 2'b00; start = 1'b1;
        step();
        start = 1'b0;
        at_neg();
        chk("midrst_restart", 64'(addr), 64'd0);
        adv = 1'b1;
        run_to_idle("midrst_end_idle", 200);

        // serpentine / fallback-to-linear mode
        mode = 2'b11; start = 1'b1;
        step();
        start = 1'b0; adv = 1'b1;
        repeat (9) step();
        at_neg();
`ifdef ONEHOT_SEQ_SERPENTINE_EN
        chk("srp_step9", 64'(addr), 64'd14);
`else
        chk("srp_step9", 64'(addr), 64'd9);
`endif
        run_to_idle("srp_end_idle", 200);

        // fully random traffic
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            start     = $urandom_range(0, 1);
            dir_valid = $urandom_range(0, 1);
            mode      = 2'($urandom_range(0, 3));
            dir_addr  = ADDR_W'($urandom);
            adv       = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0; start = 1'b0; dir_valid = 1'b0; adv = 1'b1;
        run_to_idle("rand_end_idle", 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/onehot_addr_sequencer.md
Name: onehot_addr_sequencer

Overview:
- Parametrised, registered binary-to-one-hot address sequencer for the 8x8 DCT transpose/coefficient buffer.
- Generates one-hot select strobes over 2**ADDR_W entries in one of three modes: linear scan, transposed scan, or single direct access.
- Advances only under a downstream handshake.
- Sits between the row-DCT output stage and the transpose memory write/read enables.

Parameters:
- ADDR_W, 6, binary address width; the block drives 2**ADDR_W one-hot select lines.
- COL_W, 3, width of the low (column) address field. The row field is ADDR_W-COL_W.
- Transposed mode requires ADDR_W == 2*COL_W. Elaboration fails otherwise.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a full scan; sampled only in IDLE.
- mode  in  2  00 linear, 01 transposed, 10 direct, 11 serpentine (see Optional Feature). Latched on accept.
- dir_addr  in  ADDR_W  address for direct mode.
- dir_valid  in  1  direct-access request; sampled only in IDLE with mode==10.
- adv  in  1  downstream has consumed the current strobe (ready).
- sel  out  2**ADDR_W  registered one-hot select; all-zero when sel_valid=0.
- sel_valid  out  1  sel/addr are valid.
- addr  out  ADDR_W  registered binary equivalent of sel.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse on the final accepted strobe of a scan.

Behaviour:
- Reset (synchronous, wins over all inputs):
  - state=IDLE, counter=0.
  - sel=0, addr=0, sel_valid=0, busy=0, frame_done=0.
- States: IDLE, SCAN, DIRECT.
- IDLE:
  - If mode==10 and dir_valid=1: latch mode, go to DIRECT. Next cycle sel=onehot(dir_addr), addr=dir_addr, sel_valid=1.
  - Else if mode!=10 and start=1: latch mode, counter=0, go to SCAN. Next cycle the step-0 strobe is presented with sel_valid=1.
  - start is ignored when mode==10. dir_valid is ignored when mode!=10.
  - Latency from request to first valid strobe: 1 cycle.
- SCAN:
  - The strobe is held stable until a cycle with adv=1.
  - On adv with counter < 2**ADDR_W-1: counter increments and the next strobe appears the following cycle, with no bubble.
  - On adv with counter == 2**ADDR_W-1: frame_done=1 for that cycle only. Next cycle state=IDLE, sel=0, sel_valid=0, counter=0.
  - start, dir_valid and mode changes are ignored while in SCAN.
- DIRECT: holds the strobe until adv=1, then returns to IDLE with sel cleared. frame_done is not asserted.
- Address mapping from counter c:
  - linear: addr=c.
  - transposed: addr={c[COL_W-1:0], c[ADDR_W-1:COL_W]}.
  - Example, default parameters: c=1 -> addr 8, c=9 -> addr 9, c=63 -> addr 63.
- Back-to-back scans: start may be asserted in the cycle after the return to IDLE. There is no start path in the frame_done cycle.
- sel is always exactly one-hot when sel_valid=1 and all-zero otherwise. This is a verification invariant.

Optional Feature:
- Macro: ONEHOT_SEQ_SERPENTINE_EN.
- Defined: mode 11 is serpentine. Even rows scan columns ascending; odd rows scan descending, i.e. addr={c[ADDR_W-1:COL_W], c[COL_W]? ~c[COL_W-1:0] : c[COL_W-1:0]}.
- Example: c=8 -> 15, c=15 -> 8.
- Not defined: mode 11 behaves exactly as linear (00).

Decomposition:
- Shared package dct_addr_pkg:
  - mode constants MODE_LIN=2'b00, MODE_TRN=2'b01, MODE_DIR=2'b10, MODE_SRP=2'b11.
  - state encoding typedef (IDLE/SCAN/DIRECT).
- Sub-module onehot_dec: purely combinational, parametrised by ADDR_W, binary in -> 2**ADDR_W one-hot out, with an enable input. The sequencer registers its output.

Test Plan:
- Reset mid-scan: assert rst at counter=20 -> next cycle sel=0, sel_valid=0, busy=0, and a later start begins at addr 0.
- Linear scan, adv tied high: start with mode=00 -> addr 0..63 on consecutive cycles, sel==1<<addr, frame_done only with addr 63; idle afterwards.
- Transposed scan with random adv stalls: mode=01 -> sequence 0,8,16,...,56,1,9,...,63; strobe stable during every stall.
- Direct access: mode=10, dir_addr=45, dir_valid=1 -> next cycle sel[45]=1 only, held 3 stalled cycles, clears after adv; frame_done never asserts.
- Ignored requests: start during SCAN and dir_valid with mode=00 in IDLE -> no state effect. Simultaneous start+dir_valid with mode=10 -> DIRECT.
- Serpentine mode=11: with ONEHOT_SEQ_SERPENTINE_EN the sequence is 0..7,15..8,16..23; without the macro it is identical to linear.
